mul_arbiter: RTL and testbench
==============================

// Module: mul_arbiter
// PURPOSE
//  Shares one sequential shift-add multiplier (loop: start pulse, ready, 2W-bit out) between N requesters.
//  Round-robin arbitration and req/done handshake per requester; sequences the multiplier's start/ready protocol.
//  Sits between client blocks and a single externally instantiated multiplier.
// PARAMETERS
//  N        4   number of requesters (2..8)
//  W        8   operand width; product width is 2*W
//  TIMEOUT  64  max cycles spent in either wait state before error abort
// PORTS
//  clk        in   1      clock; all state changes on rising edge
//  reset      in   1      asynchronous, active-high reset
//  req        in   N      per-requester request level; held with operands until done
//  a_in       in   N*W    operand A, requester i at [i*W +: W]
//  b_in       in   N*W    operand B, same packing
//  grant      out  N      one-hot owner of the multiplier, held START..DONE
//  done       out  N      one-cycle pulse to granted requester, result valid same cycle
//  result     out  2*W    product of last completed op; held until next DONE
//  busy       out  1      high whenever state != IDLE
//  err        out  1      sticky timeout flag; cleared only by reset
//  mul_start  out  1      one-cycle start pulse to multiplier (its reset/start input)
//  mul_a      out  W      latched operand A to multiplier
//  mul_b      out  W      latched operand B to multiplier
//  mul_ready  in   1      multiplier done/idle level
//  mul_out    in   2*W    multiplier product
// BEHAVIOUR
//  - Reset (async, any time incl. mid-op): state IDLE, grant=0, done=0, result=0, busy=0, err=0,
//    mul_start=0, mul_a=mul_b=0, rr pointer=N-1 (requester 0 wins first). Multiplier is re-started on next START.
//  - FSM: IDLE -> START -> WAIT_LO -> WAIT_HI -> DONE -> IDLE.
//  - IDLE: if |req, pick winner = first set req scanning from ptr+1 mod N; register grant, mul_a/mul_b
//    from winner's operands, ptr<=winner; -> START. No req: stay.
//  - START: mul_start=1 exactly this cycle; -> WAIT_LO.
//  - WAIT_LO: wait for mul_ready==0 (multiplier accepted start); -> WAIT_HI.
//  - WAIT_HI: wait for mul_ready==1; capture result<=mul_out; -> DONE.
//  - DONE: done[winner]=1 one cycle; grant released on exit; -> IDLE. Min 5 cycles req-sample to done.
//  - Back-to-back: a requester holding req after done is re-eligible but ranks last; others pending win first.
//  - req dropped mid-op: ignored; op completes and done still pulses. Operands sampled only in IDLE.
//  - Timeout: cycle counter reset on entry to WAIT_LO and WAIT_HI; reaching TIMEOUT in either -> err<=1,
//    result<=0, -> DONE (done still pulses, requester unblocked).
//  - Widths: result is full 2W product, no truncation; 255*255 = 65025 for W=8.
//  - grant is always one-hot or zero; done is a subset of grant.
// STRUCTURE
//  - Package mul_arb_pkg: state encoding constants (IDLE..DONE), default W, N, TIMEOUT.
//  - Sub-module rr_pick (N): inputs req, ptr; outputs one-hot gnt and index; purely combinational.
//  - Top holds FSM, ptr, operand/result registers, timeout counter.
// TESTING
//  - Single req[0], a=12, b=13 -> grant=0001, one mul_start pulse, done[0] pulse, result=156, busy low after.
//  - req=1111 held, distinct operands -> done order 0,1,2,3,0; each result matches a*b.
//  - req[2] a=255 b=255 -> result=65025; a=0 b=200 -> result=0.
//  - Model holding mul_ready=1 after start -> after TIMEOUT cycles err=1, done pulse, result=0; err stays until reset.
//  - Assert reset in WAIT_HI -> all outputs 0 immediately; next req gets fresh start and correct product.
//  - req[1] dropped during WAIT_HI -> done[1] still pulses; req[3] pending is granted next.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared types and defaults for the multiplier arbiter: FSM encoding and
// default sizing.
package mul_arb_pkg;

    localparam int N_DEF       = 4;
    localparam int W_DEF       = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from
// ptr+1 (mod N), returned both one-hot and as an index.
module rr_pick
    import mul_arb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        // k = N lands back on ptr itself, so the last owner ranks last
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr_i) + k) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one external sequential multiplier between N requesters with
// round-robin arbitration and a timeout-guarded start/ready sequence.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | no op in flight; arbitrate and latch winner's operands
//   ST_START   | mul_start pulse to the multiplier
//   ST_WAIT_LO | wait for mul_ready low (start accepted), timeout guarded
//   ST_WAIT_HI | wait for mul_ready high, capture product, timeout guarded
//   ST_DONE    | done pulse to the owner; grant released on exit
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   a_in,
    input  logic [N*W-1:0]   b_in,
    output logic [N-1:0]     grant,
    output logic [N-1:0]     done,
    output logic [2*W-1:0]   result,
    output logic             busy,
    output logic             err,
    output logic             mul_start,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic             mul_ready,
    input  logic [2*W-1:0]   mul_out
);

    localparam int IW = idx_w(N);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [2*W-1:0]  result_q, result_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [N-1:0]    pick_gnt;
    logic [IW-1:0]   pick_idx;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            ptr_q    <= IW'(N - 1);
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = pick_gnt;
                    ptr_d   = pick_idx;
                    a_d     = a_in[pick_idx*W +: W];
                    b_d     = b_in[pick_idx*W +: W];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = TO_LOAD;
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!mul_ready) begin
                    cnt_d   = TO_LOAD;
                    state_d = ST_WAIT_HI;
                end else if (cnt_q == '0) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_WAIT_HI: begin
                if (mul_ready) begin
                    result_d = mul_out;
                    state_d  = ST_DONE;
                end else if (cnt_q == '0) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant     = grant_q;
    assign done      = (state_q == ST_DONE) ? grant_q : '0;
    assign result    = result_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign mul_start = (state_q == ST_START);
    assign mul_a     = a_q;
    assign mul_b     = b_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural multiplier and a
// scoreboard of expected (owner, product) pairs popped on each done pulse.
module tb_mul_arbiter;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*W-1:0]   a_in;
    logic [N*W-1:0]   b_in;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic [2*W-1:0]   result;
    logic             busy;
    logic             err;
    logic             mul_start;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic             mul_ready;
    logic [2*W-1:0]   mul_out;

    mul_arbiter #(
        .N       (N),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .grant     (grant),
        .done      (done),
        .result    (result),
        .busy      (busy),
        .err       (err),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_ready (mul_ready),
        .mul_out   (mul_out)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: ready drops after start, product appears 8 cycles later.
    // In stuck mode it ignores start and keeps ready high with a junk product.
    logic       stuck;
    logic       m_busy;
    logic [3:0] m_cnt;
    logic [W-1:0] m_a, m_b;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_ready <= 1'b1;
            mul_out   <= 16'hBEEF;
            m_busy    <= 1'b0;
            m_cnt     <= '0;
            m_a       <= '0;
            m_b       <= '0;
        end else if (stuck) begin
            mul_ready <= 1'b1;
            mul_out   <= 16'hBEEF;
            m_busy    <= 1'b0;
        end else if (mul_start) begin
            mul_ready <= 1'b0;
            m_busy    <= 1'b1;
            m_cnt     <= 4'd7;
            m_a       <= mul_a;
            m_b       <= mul_b;
        end else if (m_busy) begin
            if (m_cnt == 4'd0) begin
                mul_ready <= 1'b1;
                mul_out   <= 16'(m_a) * 16'(m_b);
                m_busy    <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 4'd1;
            end
        end
    end

    typedef struct {
        int             idx;
        logic [2*W-1:0] prod;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   dones    = 0;
    int   starts   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t        e;
        logic [N-1:0] ev;
        @(negedge clk);
        if (mul_start) starts++;
        if (|done) begin
            dones++;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e       = sb.pop_front();
                ev      = '0;
                ev[e.idx] = 1'b1;
                check("done_vec", 32'(done), 32'(ev));
                check("done_in_grant", 32'(done & ~grant), 32'd0);
                check("result", 32'(result), 32'(e.prod));
            end
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    task automatic push_exp(input int i, input logic [2*W-1:0] p);
        exp_t e;
        e.idx  = i;
        e.prod = p;
        sb.push_back(e);
    endtask

    task automatic push_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        push_exp(i, p);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_mul_start"}, 32'(mul_start), 32'd0);
        check({tag, "_mul_a"}, 32'(mul_a), 32'd0);
        check({tag, "_mul_b"}, 32'(mul_b), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        check_cleared(tag);
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_start(input string tag, input logic [N-1:0] exp_gnt);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!mul_start && n < 50);
        check({tag, "_start_seen"}, 32'(mul_start), 32'd1);
        check({tag, "_grant"}, 32'(grant), 32'(exp_gnt));
    endtask

    task automatic wait_dones(input string tag, input int k, input int budget);
        int target = dones + k;
        int n = 0;
        while (dones < target && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_dones_in_time"}, 32'(dones >= target), 32'd1);
    endtask

    initial begin
        int s0;
        int n;
        reset = 1'b1;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        stuck = 1'b0;

        do_reset("reset");

        // single requester, 12*13
        set_op(0, 8'd12, 8'd13);
        push_op(0, 8'd12, 8'd13);
        s0  = starts;
        req = 4'b0001;
        wait_start("single", 4'b0001);
        check("single_mul_a", 32'(mul_a), 32'd12);
        check("single_mul_b", 32'(mul_b), 32'd13);
        wait_dones("single", 1, 100);
        req = '0;
        tick();
        tick();
        check("single_busy_after", 32'(busy), 32'd0);
        check("single_result_held", 32'(result), 32'd156);
        check("single_grant_after", 32'(grant), 32'd0);
        check("single_one_start", 32'(starts - s0), 32'd1);

        // all four held: fresh pointer gives 0,1,2,3,0
        do_reset("reset_rr");
        set_op(0, 8'd3, 8'd4);
        set_op(1, 8'd5, 8'd6);
        set_op(2, 8'd7, 8'd8);
        set_op(3, 8'd9, 8'd10);
        push_op(0, 8'd3, 8'd4);
        push_op(1, 8'd5, 8'd6);
        push_op(2, 8'd7, 8'd8);
        push_op(3, 8'd9, 8'd10);
        push_op(0, 8'd3, 8'd4);
        req = 4'b1111;
        wait_dones("rr", 5, 300);
        req = '0;
        tick();
        tick();
        check("rr_drained", 32'(sb.size()), 32'd0);
        check("rr_busy_after", 32'(busy), 32'd0);

        // width boundaries on requester 2
        set_op(2, 8'd255, 8'd255);
        push_exp(2, 16'd65025);
        req = 4'b0100;
        wait_dones("max", 1, 100);
        req = '0;
        tick();
        set_op(2, 8'd0, 8'd200);
        push_exp(2, 16'd0);
        req = 4'b0100;
        wait_dones("zero", 1, 100);
        req = '0;
        tick();

        // multiplier never drops ready: timeout abort
        stuck = 1'b1;
        set_op(1, 8'd9, 8'd9);
        push_exp(1, 16'd0);
        req = 4'b0010;
        wait_start("to", 4'b0010);
        n = 0;
        while (!(|done) && n < 200) begin
            tick();
            n++;
        end
        check("to_latency", 32'(n), 32'(TIMEOUT + 1));
        check("to_err", 32'(err), 32'd1);
        req   = '0;
        stuck = 1'b0;
        tick();
        tick();
        check("to_err_sticky_idle", 32'(err), 32'd1);
        set_op(0, 8'd3, 8'd5);
        push_op(0, 8'd3, 8'd5);
        req = 4'b0001;
        wait_dones("after_to", 1, 100);
        req = '0;
        tick();
        check("to_err_sticky_op", 32'(err), 32'd1);
        do_reset("reset_err");

        // reset during WAIT_HI
        set_op(3, 8'd7, 8'd9);
        req = 4'b1000;
        wait_start("rst", 4'b1000);
        tick();
        tick();
        tick();
        check("rst_in_wait_hi_ready", 32'(mul_ready), 32'd0);
        check("rst_in_wait_hi_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1 check_cleared("rst_mid");
        push_op(3, 8'd7, 8'd9);
        tick();
        reset = 1'b0;
        s0 = starts;
        wait_start("rst_again", 4'b1000);
        wait_dones("rst_again", 1, 100);
        req = '0;
        tick();
        check("rst_again_one_start", 32'(starts - s0), 32'd1);

        // req[1] dropped mid-op, req[3] pending is served next
        set_op(1, 8'd20, 8'd30);
        set_op(3, 8'd100, 8'd250);
        push_op(1, 8'd20, 8'd30);
        push_op(3, 8'd100, 8'd250);
        req = 4'b1010;
        wait_start("drop", 4'b0010);
        tick();
        tick();
        tick();
        req[1] = 1'b0;
        wait_dones("drop", 2, 100);
        req = '0;
        tick();
        tick();
        check("drop_drained", 32'(sb.size()), 32'd0);
        check("drop_busy_after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
